// File: rtl/keccak_pkg.sv
// Shared constants, state encoding and rate table for the SHA-3 absorb front end.
package keccak_pkg;

  localparam int W         = 64;
  localparam int MAX_WORDS = 18;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PAD_FILL,
    FULL
  } state_e;

  // Rate in 64-bit words for each digest size.
  function automatic logic [4:0] rate_words(input logic [1:0] mode);
    logic [4:0] r;
    unique case (mode)
      2'b00:   r = 5'd18;
      2'b01:   r = 5'd17;
      2'b10:   r = 5'd13;
      default: r = 5'd9;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Builds one padded word: kept message bytes, optional domain byte,
// and the final 0x80 bit when the word lands in the last rate slot.
module keccak_pad_word
  import keccak_pkg::*;
(
  input  logic [63:0] in,
  input  logic [2:0]  byte_num,
  input  logic        dom_en,
  input  logic        is_final_slot,
  output logic [63:0] out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(byte_num)) begin
        out[8*k +: 8] = in[8*k +: 8];
      end else if (k == int'(byte_num) && dom_en) begin
        out[8*k +: 8] = PAD_DOMAIN;
      end
    end
    if (is_final_slot) begin
      out[63:56] = out[63:56] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Word-stream absorber: pads the message and assembles rate-sized
// blocks for the permutation, holding each block until f_ack.
module keccak_padder
  import keccak_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   in,
  input  logic          in_valid,
  input  logic          is_last,
  input  logic [2:0]    byte_num,
  input  logic [1:0]    mode,
  output logic          ack,
  output logic [1151:0] out,
  output logic          out_valid,
  input  logic          f_ack
);

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   rate_q, rate_d;
  logic         last_blk_q, last_blk_d;
  logic         ack_q, ack_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] buf_q [MAX_WORDS];
  logic [W-1:0] buf_d [MAX_WORDS];

  logic [4:0]   rate_cur;
  logic         final_slot;
  logic         pad_fill;
  logic [63:0]  pad_in;
  logic [2:0]   pad_bn;
  logic [63:0]  pad_word;
  logic         wr_en;
  logic [63:0]  wr_data;
  logic         clr;

  // In IDLE the rate is not latched yet; the first word uses mode directly.
  always_comb begin
    rate_cur   = (state_q == IDLE) ? rate_words(mode) : rate_q;
    final_slot = (cnt_q == rate_cur - 5'd1);
    pad_fill   = (state_q == PAD_FILL);
    pad_in     = pad_fill ? 64'd0 : in;
    pad_bn     = pad_fill ? 3'd0 : byte_num;
  end

  keccak_pad_word u_pad (
    .in            (pad_in),
    .byte_num      (pad_bn),
    .dom_en        (!pad_fill),
    .is_final_slot (final_slot),
    .out           (pad_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rate_d     = rate_q;
    last_blk_d = last_blk_q;
    wr_en      = 1'b0;
    wr_data    = in;
    clr        = 1'b0;
    unique case (state_q)
      IDLE, ABSORB: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (state_q == IDLE) begin
            rate_d = rate_cur;
          end
          if (is_last) begin
            wr_data    = pad_word;
            last_blk_d = 1'b1;
            if (final_slot) begin
              state_d = FULL;
            end else begin
              state_d = PAD_FILL;
              cnt_d   = cnt_q + 5'd1;
            end
          end else if (final_slot) begin
            state_d = FULL;
          end else begin
            state_d = ABSORB;
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      PAD_FILL: begin
        wr_en   = 1'b1;
        wr_data = pad_word;
        if (final_slot) begin
          state_d = FULL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FULL: begin
        if (f_ack) begin
          clr        = 1'b1;
          cnt_d      = 5'd0;
          last_blk_d = 1'b0;
          state_d    = last_blk_q ? IDLE : ABSORB;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < MAX_WORDS; i++) begin
      if (clr) begin
        buf_d[i] = '0;
      end else if (wr_en && cnt_q == 5'(i)) begin
        buf_d[i] = wr_data;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end

    ack_d       = (state_d == IDLE) || (state_d == ABSORB);
    out_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rate_q      <= 5'(MAX_WORDS);
      last_blk_q  <= 1'b0;
      ack_q       <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      last_blk_q  <= last_blk_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // ack is held low while reset is being applied.
  assign ack       = ack_q & ~rst;
  assign out_valid = out_valid_q;

  always_comb begin
    for (int i = 0; i < MAX_WORDS; i++) begin
      out[64*i +: 64] = buf_q[i];
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder.
module tb_keccak_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   in;
  logic          in_valid;
  logic          is_last;
  logic [2:0]    byte_num;
  logic [1:0]    mode;
  logic          ack;
  logic [1151:0] out;
  logic          out_valid;
  logic          f_ack;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_w [18];
  logic [63:0] snap;

  keccak_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .is_last   (is_last),
    .byte_num  (byte_num),
    .mode      (mode),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .f_ack     (f_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int i);
    return out[64*i +: 64];
  endfunction

  task automatic clr_exp();
    for (int i = 0; i < 18; i++) exp_w[i] = '0;
  endtask

  task automatic chk_blk(input string tag);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("%s_w%0d", tag, i), word(i), exp_w[i]);
    end
  endtask

  // Present one word; ack must be high so it transfers on this edge.
  task automatic send(input logic [63:0] w, input logic last,
                      input logic [2:0] bn);
    chk("send_ack", {63'd0, ack}, 64'd1);
    in       = w;
    in_valid = 1'b1;
    is_last  = last;
    byte_num = bn;
    step();
    in_valid = 1'b0;
    is_last  = 1'b0;
  endtask

  // Cycles until out_valid rises, bounded.
  task automatic wait_valid(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic do_f_ack();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk("fack_ov", {63'd0, out_valid}, 64'd0);
    chk("fack_ack", {63'd0, ack}, 64'd1);
    chk("fack_clr", word(0), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in       = '0;
    in_valid = 1'b0;
    is_last  = 1'b0;
    byte_num = '0;
    mode     = 2'b01;
    f_ack    = 1'b0;

    // Reset
    step();
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ack", {63'd0, ack}, 64'd1);
    clr_exp();
    chk_blk("rst_out");

    // Empty message, mode 01
    send(64'hDEAD_BEEF_0123_4567, 1'b1, 3'd0);
    chk("empty_ack_fill", {63'd0, ack}, 64'd0);
    wait_valid("empty_lat", 16);
    clr_exp();
    exp_w[0]  = 64'h6;
    exp_w[16] = 64'h8000_0000_0000_0000;
    chk_blk("empty");
    do_f_ack();

    // "abc", mode 11
    mode = 2'b11;
    send(64'hFFFF_FFFF_FF63_6261, 1'b1, 3'd3);
    wait_valid("abc_lat", 8);
    clr_exp();
    exp_w[0] = 64'h0000_0000_0663_6261;
    exp_w[8] = 64'h8000_0000_0000_0000;
    chk_blk("abc");
    do_f_ack();

    // Mode 11, eight words then is_last byte_num 7; mode toggles mid-message
    mode = 2'b11;
    clr_exp();
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
      send(exp_w[i], 1'b0, 3'd0);
      mode = (i % 2 == 0) ? 2'b00 : 2'b10;
    end
    chk("m11_ov_early", {63'd0, out_valid}, 64'd0);
    send(64'h55AA_BBCC_DDEE_FF11, 1'b1, 3'd7);
    exp_w[8] = 64'h86AA_BBCC_DDEE_FF11;
    chk("m11_ov_next", {63'd0, out_valid}, 64'd1);
    chk_blk("m11");

    // Backpressure: 20 cycles without f_ack, in_valid held high
    snap     = word(3);
    in       = 64'h1234_5678_9ABC_DEF0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_ack", {63'd0, ack}, 64'd0);
      chk("bp_ov", {63'd0, out_valid}, 64'd1);
      chk("bp_w3", word(3), snap);
    end
    in_valid = 1'b0;
    chk_blk("bp_final");
    do_f_ack();

    // Mode 01, 17 words then empty is_last; f_ack pulsed outside FULL
    mode = 2'b01;
    clr_exp();
    f_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_w[i] = {32'hC0DE_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)};
      send(exp_w[i], 1'b0, 3'd0);
      if (i == 2) f_ack = 1'b0;
    end
    chk("m01_ov_next", {63'd0, out_valid}, 64'd1);
    chk_blk("m01_blk1");
    step();
    step();
    chk("m01_ov_hold", {63'd0, out_valid}, 64'd1);
    chk("m01_ack_hold", {63'd0, ack}, 64'd0);
    do_f_ack();
    mode = 2'b11;
    send(64'h0, 1'b1, 3'd0);
    wait_valid("m01_blk2_lat", 16);
    clr_exp();
    exp_w[0]  = 64'h6;
    exp_w[16] = 64'h8000_0000_0000_0000;
    chk_blk("m01_blk2");
    do_f_ack();

    // Reset after 5 words
    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      send(64'hFEED_0000_0000_0000 + 64'(i), 1'b0, 3'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ov", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ack", {63'd0, ack}, 64'd1);
    clr_exp();
    chk_blk("mid_rst_out");
    send(64'h0, 1'b1, 3'd0);
    wait_valid("again_lat", 16);
    exp_w[0]  = 64'h6;
    exp_w[16] = 64'h8000_0000_0000_0000;
    chk_blk("again");
    do_f_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keccak_padder.md
# keccak_padder

Absorb-side front end of the SHA-3 core: accepts the message as a stream of 64-bit words, applies SHA-3 padding (domain bits 0x06, final 0x80), and assembles rate-sized blocks for `f_permutation`. Sits between the host word interface (`in`/`in_valid`/`is_last`/`ack`) and the permutation's block input. Block size follows `mode`.

## Interface
- `W`, 64, word width (fixed; lane width)
- `MAX_WORDS`, 18, block buffer depth in words (largest rate, 1152 bits)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in` in 64: message word; byte k at `in[8k+7:8k]`.
- `in_valid` in 1: `in` is valid this cycle.
- `is_last` in 1: the current word ends the message; qualified by `in_valid`.
- `byte_num` in 3: count of valid bytes (0–7) in an `is_last` word; ignored otherwise.
- `mode` in 2: digest select. 00 = 224 (18 words), 01 = 256 (17), 10 = 384 (13), 11 = 512 (9).
- `ack` out 1: padder accepts a word this cycle. Transfer occurs when `in_valid && ack`.
- `out` out 1152: block; word i at `out[64i+63:64i]`; words ≥ rate are zero.
- `out_valid` out 1: `out` holds a complete block.
- `f_ack` in 1: permutation consumes the block this cycle.

## Operation
- States: IDLE, ABSORB, PAD_FILL, FULL. Block state is in `buf[0..17]`, `cnt` (0..17), `rate` (latched), `last_blk` flag.
- IDLE: `ack` = 1. The first accepted word latches `rate` from `mode` and moves to ABSORB, with `mode` sampled on that cycle only. `mode` changes mid-message are ignored.
- ABSORB: `ack` = 1. Each accepted non-last word writes `buf[cnt]` and increments `cnt`.
- Padding word: an accepted `is_last` word writes `buf[cnt]`:
  - bytes < `byte_num` come from `in`;
  - byte `byte_num` = 0x06;
  - higher bytes = 0.
  - Then set `last_blk`.
- A message whose length is a multiple of 8 bytes ends with an `is_last` word carrying `byte_num` = 0. Its data is ignored and the word becomes 0x06.
- Final-byte rule: word `rate-1`, byte 7 is ORed with 0x80. When the padding word lands in slot `rate-1` with `byte_num` = 7, that byte becomes 0x86.
- After the padding word:
  - if `cnt` = `rate-1`, go to FULL;
  - otherwise go to PAD_FILL, which writes one zero word per cycle (slot `rate-1` gets 0x80 in byte 7) until `rate-1` is written, then goes to FULL.
  - `ack` = 0 in PAD_FILL.
- Non-last word into slot `rate-1`: go to FULL.
- FULL: `ack` = 0, `out_valid` = 1, `out` stable. On `f_ack`:
  - clear `buf` and set `cnt` = 0;
  - go to IDLE if `last_blk` (clearing it), else to ABSORB.
- `f_ack` outside FULL is ignored.
- An `is_last` word accepted in IDLE is a one-word message and is valid.

## Timing
- Reset values: `ack` = 0 during the reset cycle, then 1 (IDLE). `out_valid` = 0, `out` = 0, `cnt` = 0, `last_blk` = 0.
- `ack` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `f_ack`.
- Accepted word into slot `rate-1`: `out_valid` = 1 on the next cycle.
- Padding word into slot c < `rate-1`: `out_valid` rises `rate-1-c` cycles after the following edge (PAD_FILL length).
- The `f_ack` edge drops `out_valid` and raises `ack` on the next cycle. The earliest next accept is one cycle after `f_ack`.
- Maximum throughput: `rate` words plus 1 handoff cycle per block.
- `rst` mid-message: the next cycle is IDLE with all state cleared. A partial block is discarded and `out_valid` is never asserted for it.

## Structure
- `keccak_pkg`: rate-in-words table indexed by `mode`, `PAD_DOMAIN` = 8'h06, `PAD_FINAL` = 8'h80, state enum, `MAX_WORDS`.
- Padding-word byte mux as a small combinational sub-module `keccak_pad_word` (inputs `in`, `byte_num`, `is_final_slot`; output padded word), reused by PAD_FILL with `byte_num` = 0 and data zero.
- FSM, counter and buffer live in `keccak_padder`.

## Test plan
- Empty message, mode 01: one `is_last` word with `byte_num` = 0.
  - Response: after 16 PAD_FILL cycles, `out_valid` = 1.
  - `out` word0 = 0x06, word16 = 0x8000000000000000, all others 0.
- 3-byte message "abc" (`in` = 0x636261, `is_last`, `byte_num` = 3), mode 11.
  - Response: word0 = 0x0000000006636261, word8 = 0x8000000000000000, words 9–17 = 0.
- Mode 11, eight full words followed by `is_last` with `byte_num` = 7.
  - Response: no PAD_FILL; `out_valid` on the next cycle; word8 byte 7 = 0x86.
- Mode 01, 17 full words then an empty `is_last`.
  - Response: first block = the 17 words, `out_valid` held until `f_ack`.
  - After `f_ack`, `ack` returns; second block = word0 0x06, word16 0x80<<56.
- Backpressure: hold `f_ack` = 0 for 20 cycles while `in_valid` = 1.
  - Response: `ack` = 0 throughout and `out` is unchanged.
  - Toggling `mode` during the message does not change `rate`.
- Assert `rst` for one cycle after 5 words.
  - Response: `cnt` = 0, `out_valid` = 0, `ack` = 1 afterwards.
  - A new empty message then produces the same block as the first scenario.
